// File: rtl/game_pkg.sv
// Shared game constants: score-event kinds and the default score register /
// win threshold, so injection logic, monitor and display agree on them.
package game_pkg;

   localparam int EVT_KIND_W = 2;

   // Event kind encoding seen by audio/VGA/LED consumers; 00 never leaves the FIFO.
   typedef enum logic [EVT_KIND_W-1:0] {
      EVT_NONE = 2'b00,
      EVT_UP   = 2'b01,
      EVT_DOWN = 2'b10,
      EVT_WIN  = 2'b11
   } evt_kind_e;

   localparam int SCORE_REG_DEFAULT = 30;
   localparam int WIN_SCORE_DEFAULT = 12;

endpackage

// File: rtl/evt_fifo.sv
// Synchronous valid/ready FIFO with a registered head. A push into a full
// FIFO is accepted only when a pop happens on the same edge; otherwise it is
// refused (the caller decides what a refused push means).
module evt_fifo #(
   parameter int WIDTH = 34,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output logic             full_o,
   output logic             empty_o,
   output logic             valid_o,
   output logic [WIDTH-1:0] head_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             valid_q;
   logic [WIDTH-1:0] head_q, head_d;
   logic             full_s;
   logic             push_ok_s;
   logic             pop_ok_s;

   // Next-state for pointers, occupancy and the head register.
   always_comb begin
      full_s    = (count_q == CNT_W'(DEPTH));
      pop_ok_s  = pop_i && valid_q;
      push_ok_s = push_i && (!full_s || pop_ok_s);

      if (push_ok_s) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end

      if (pop_ok_s) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end

      if (push_ok_s && !pop_ok_s) begin
         count_d = count_q + CNT_W'(1);
      end else if (pop_ok_s && !push_ok_s) begin
         count_d = count_q - CNT_W'(1);
      end else begin
         count_d = count_q;
      end

      // The incoming entry becomes the head when it lands in the slot the
      // read pointer will point at (empty FIFO, or popping the last entry).
      if (push_ok_s && (wr_ptr_q == rd_ptr_d)) begin
         head_d = push_data_i;
      end else begin
         head_d = mem_q[rd_ptr_d];
      end
   end

   // Entry storage; needs no reset because the pointers define validity.
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

   // Pointer, occupancy and registered-head state; reset flushes the FIFO.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         valid_q  <= 1'b0;
         head_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         valid_q  <= (count_d != CNT_W'(0));
         head_q   <= head_d;
      end
   end

   assign full_o  = full_s;
   assign empty_o = !valid_q;
   assign valid_o = valid_q;
   assign head_o  = head_q;

endmodule

// File: rtl/score_write_monitor.sv
// Passive monitor on the regfile write port: shadows the score register,
// classifies each change as UP / DOWN / WIN, queues the events for the
// feedback consumers and holds a sticky game-over level.
module score_write_monitor
   import game_pkg::*;
#(
   parameter int SCORE_REG  = SCORE_REG_DEFAULT,
   parameter int DATA_W     = 32,
   parameter int WIN_SCORE  = WIN_SCORE_DEFAULT,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [4:0]        wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              game_clear,
   output logic              evt_valid,
   input  logic              evt_ready,
   output logic [1:0]        evt_kind,
   output logic [DATA_W-1:0] evt_score,
   output logic [DATA_W-1:0] score,
   output logic              game_over,
   output logic              overflow
);

   localparam logic [4:0]        SCORE_IDX = 5'(SCORE_REG);
   localparam logic [DATA_W-1:0] WIN_VAL   = DATA_W'(WIN_SCORE);
   localparam int                ENTRY_W   = EVT_KIND_W + DATA_W;

   logic [DATA_W-1:0]  score_q;
   logic               game_over_q;
   logic               overflow_q;
   logic               score_wr_s;
   logic               evt_gen_s;
   logic               is_win_s;
   evt_kind_e          kind_s;
   logic               fifo_full_s;
   logic               fifo_empty_s;
   logic               fifo_valid_s;
   logic               fifo_pop_s;
   logic               drop_s;
   logic [ENTRY_W-1:0] head_s;

   // Decode score writes and classify the change against the shadow score.
   always_comb begin
      score_wr_s = wr_en && (wr_addr == SCORE_IDX);
      evt_gen_s  = score_wr_s && (wr_data != score_q);
      is_win_s   = (score_q < WIN_VAL) && (wr_data >= WIN_VAL);
      if (is_win_s) begin
         kind_s = EVT_WIN;
      end else if (wr_data > score_q) begin
         kind_s = EVT_UP;
      end else begin
         kind_s = EVT_DOWN;
      end
      fifo_pop_s = !fifo_empty_s && evt_ready;
      // A full FIFO only takes a new event if the head leaves on the same edge.
      drop_s     = evt_gen_s && fifo_full_s && !fifo_pop_s;
   end

   // Shadow score, sticky game-over (set beats clear) and sticky overflow.
   always_ff @(posedge clk) begin
      if (reset) begin
         score_q     <= '0;
         game_over_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         if (evt_gen_s) begin
            score_q <= wr_data;
         end else begin
            score_q <= score_q;
         end
         if (evt_gen_s && is_win_s) begin
            game_over_q <= 1'b1;
         end else if (game_clear) begin
            game_over_q <= 1'b0;
         end else begin
            game_over_q <= game_over_q;
         end
         if (drop_s) begin
            overflow_q <= 1'b1;
         end else begin
            overflow_q <= overflow_q;
         end
      end
   end

   evt_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_evt_fifo (
      .clk         (clk),
      .reset       (reset),
      .push_i      (evt_gen_s),
      .push_data_i ({kind_s, wr_data}),
      .pop_i       (evt_ready),
      .full_o      (fifo_full_s),
      .empty_o     (fifo_empty_s),
      .valid_o     (fifo_valid_s),
      .head_o      (head_s)
   );

   assign evt_valid = fifo_valid_s;
   assign evt_kind  = head_s[ENTRY_W-1 -: EVT_KIND_W];
   assign evt_score = head_s[DATA_W-1:0];
   assign score     = score_q;
   assign game_over = game_over_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_score_write_monitor.sv
// Self-checking bench for score_write_monitor: directed scenarios with
// constant expectations plus a randomized run against a queue-based model.
module tb_score_write_monitor;

   logic        clk = 1'b0;
   logic        reset;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic        game_clear;
   logic        evt_valid;
   logic        evt_ready;
   logic [1:0]  evt_kind;
   logic [31:0] evt_score;
   logic [31:0] score;
   logic        game_over;
   logic        overflow;

   int total = 0;
   int bad   = 0;

   // Reference model state: event queue of {kind, score}.
   logic [33:0] mq[$];
   logic [31:0] m_score;
   logic        m_go;
   logic        m_ovf;

   score_write_monitor dut (
      .clk        (clk),
      .reset      (reset),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .game_clear (game_clear),
      .evt_valid  (evt_valid),
      .evt_ready  (evt_ready),
      .evt_kind   (evt_kind),
      .evt_score  (evt_score),
      .score      (score),
      .game_over  (game_over),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   // Apply one rising edge to the model, then move to the sampling edge.
   task automatic cycle();
      logic       pop;
      logic       was_full;
      logic       win;
      logic [1:0] kind;
      @(posedge clk);
      if (reset) begin
         mq.delete();
         m_score = 32'd0;
         m_go    = 1'b0;
         m_ovf   = 1'b0;
      end else begin
         pop      = (mq.size() != 0) && evt_ready;
         was_full = (mq.size() == 4);
         win      = 1'b0;
         if (pop) void'(mq.pop_front());
         if (wr_en && wr_addr == 5'd30 && wr_data != m_score) begin
            win  = (m_score < 32'd12) && (wr_data >= 32'd12);
            kind = win ? 2'b11 : (wr_data > m_score) ? 2'b01 : 2'b10;
            if (was_full && !pop) m_ovf = 1'b1;
            else mq.push_back({kind, wr_data});
            m_score = wr_data;
         end
         if (win) m_go = 1'b1;
         else if (game_clear) m_go = 1'b0;
      end
      @(negedge clk);
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic en);
      wr_en   = en;
      wr_addr = a;
      wr_data = d;
      cycle();
      wr_en   = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1; wr_en = 1'b0; game_clear = 1'b0; evt_ready = 1'b0;
      cycle();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      if ({evt_valid, evt_kind, evt_score, score, game_over, overflow} !== 68'd0) begin
         bad++;
         $display("FAIL reset valid=%0b kind=%0b evs=%0d score=%0d go=%0b ovf=%0b want all 0",
                  evt_valid, evt_kind, evt_score, score, game_over, overflow);
      end
      total++;
   endtask

   task automatic test_up_down();
      do_reset();
      evt_ready = 1'b1;
      wr(5'd30, 32'd1, 1'b1);
      if (evt_valid !== 1'b1 || evt_kind !== 2'b01 || evt_score !== 32'd1 || score !== 32'd1) begin
         bad++;
         $display("FAIL up1 got v=%0b k=%0b s=%0d score=%0d want 1/01/1/1", evt_valid, evt_kind, evt_score, score);
      end
      total++;
      wr(5'd30, 32'd0, 1'b1);
      if (evt_valid !== 1'b1 || evt_kind !== 2'b10 || evt_score !== 32'd0 || score !== 32'd0) begin
         bad++;
         $display("FAIL down0 got v=%0b k=%0b s=%0d score=%0d want 1/10/0/0", evt_valid, evt_kind, evt_score, score);
      end
      total++;
   endtask

   task automatic test_win();
      do_reset();
      evt_ready = 1'b1;
      wr(5'd30, 32'd11, 1'b1);
      if (evt_kind !== 2'b01 || evt_score !== 32'd11 || game_over !== 1'b0) begin
         bad++;
         $display("FAIL up11 got k=%0b s=%0d go=%0b want 01/11/0", evt_kind, evt_score, game_over);
      end
      total++;
      wr(5'd30, 32'd12, 1'b1);
      if (evt_valid !== 1'b1 || evt_kind !== 2'b11 || evt_score !== 32'd12 || game_over !== 1'b1) begin
         bad++;
         $display("FAIL win12 got v=%0b k=%0b s=%0d go=%0b want 1/11/12/1", evt_valid, evt_kind, evt_score, game_over);
      end
      total++;
      wr(5'd30, 32'd5, 1'b1);
      if (evt_kind !== 2'b10 || evt_score !== 32'd5 || game_over !== 1'b1) begin
         bad++;
         $display("FAIL down5 got k=%0b s=%0d go=%0b want 10/5/1", evt_kind, evt_score, game_over);
      end
      total++;
      game_clear = 1'b1;
      cycle();
      game_clear = 1'b0;
      if (game_over !== 1'b0) begin
         bad++;
         $display("FAIL clear got go=%0b want 0", game_over);
      end
      total++;
   endtask

   task automatic test_overflow();
      do_reset();
      for (int i = 1; i <= 5; i++) wr(5'd30, 32'(i), 1'b1);
      if (overflow !== 1'b1 || score !== 32'd5 || evt_valid !== 1'b1) begin
         bad++;
         $display("FAIL ovf got ovf=%0b score=%0d v=%0b want 1/5/1", overflow, score, evt_valid);
      end
      total++;
      evt_ready = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         if (evt_valid !== 1'b1 || evt_kind !== 2'b01 || evt_score !== 32'(k)) begin
            bad++;
            $display("FAIL drain%0d got v=%0b k=%0b s=%0d want 1/01/%0d", k, evt_valid, evt_kind, evt_score, k);
         end
         total++;
         cycle();
      end
      if (evt_valid !== 1'b0) begin
         bad++;
         $display("FAIL drained got v=%0b want 0", evt_valid);
      end
      total++;
   endtask

   task automatic test_back_to_back();
      int exp_s[4];
      exp_s = '{2, 3, 4, 6};
      do_reset();
      for (int i = 1; i <= 4; i++) wr(5'd30, 32'(i), 1'b1);
      evt_ready = 1'b1;
      wr(5'd30, 32'd6, 1'b1);
      if (overflow !== 1'b0 || evt_kind !== 2'b01 || evt_score !== 32'd2) begin
         bad++;
         $display("FAIL fullpp got ovf=%0b k=%0b s=%0d want 0/01/2", overflow, evt_kind, evt_score);
      end
      total++;
      for (int k = 0; k < 4; k++) begin
         if (evt_valid !== 1'b1 || evt_score !== 32'(exp_s[k])) begin
            bad++;
            $display("FAIL fullpp_drain%0d got v=%0b s=%0d want 1/%0d", k, evt_valid, evt_score, exp_s[k]);
         end
         total++;
         cycle();
      end
      if (evt_valid !== 1'b0) begin
         bad++;
         $display("FAIL fullpp_empty got v=%0b want 0", evt_valid);
      end
      total++;
   endtask

   task automatic test_ignored();
      logic [4:0] addrs[4];
      logic       ens[4];
      addrs = '{5'd30, 5'd29, 5'd0, 5'd30};
      ens   = '{1'b0, 1'b1, 1'b1, 1'b1};
      do_reset();
      evt_ready = 1'b1;
      wr(5'd30, 32'd7, 1'b1);
      for (int k = 0; k < 4; k++) begin
         wr(addrs[k], (k == 3) ? 32'd7 : 32'd9, ens[k]);
         if (evt_valid !== 1'b0 || score !== 32'd7) begin
            bad++;
            $display("FAIL ignore%0d got v=%0b score=%0d want 0/7", k, evt_valid, score);
         end
         total++;
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      wr(5'd30, 32'd12, 1'b1);
      wr(5'd30, 32'd3, 1'b1);
      wr(5'd30, 32'd4, 1'b1);
      if (game_over !== 1'b1 || evt_kind !== 2'b11 || evt_score !== 32'd12) begin
         bad++;
         $display("FAIL premid got go=%0b k=%0b s=%0d want 1/11/12", game_over, evt_kind, evt_score);
      end
      total++;
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      if ({evt_valid, evt_kind, evt_score, score, game_over, overflow} !== 68'd0) begin
         bad++;
         $display("FAIL midreset valid=%0b kind=%0b evs=%0d score=%0d go=%0b ovf=%0b want all 0",
                  evt_valid, evt_kind, evt_score, score, game_over, overflow);
      end
      total++;
   endtask

   task automatic test_random();
      int r;
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         reset      = ($urandom_range(0, 299) == 0);
         wr_en      = ($urandom_range(0, 3) != 0);
         r          = $urandom_range(0, 9);
         wr_addr    = (r < 6) ? 5'd30 : (r == 6) ? 5'd29 : (r == 7) ? 5'd0 : 5'($urandom);
         wr_data    = ($urandom_range(0, 3) == 0) ? m_score : 32'($urandom_range(0, 20));
         if ($urandom_range(0, 40) == 0) wr_data = $urandom;
         evt_ready  = ((i % 64) < 20) ? 1'b0 : ($urandom_range(0, 2) != 0);
         game_clear = ($urandom_range(0, 7) == 0);
         cycle();
         if (evt_valid !== (mq.size() != 0) || score !== m_score || game_over !== m_go || overflow !== m_ovf) begin
            bad++;
            $display("FAIL rnd%0d got v=%0b sc=%0d go=%0b ovf=%0b want %0b/%0d/%0b/%0b", i, evt_valid, score,
                     game_over, overflow, (mq.size() != 0), m_score, m_go, m_ovf);
         end
         total++;
         if (mq.size() != 0) begin
            if ({evt_kind, evt_score} !== mq[0]) begin
               bad++;
               $display("FAIL rnd_head%0d got k=%0b s=%0d want k=%0b s=%0d", i, evt_kind, evt_score,
                        mq[0][33:32], mq[0][31:0]);
            end
            total++;
         end
      end
      reset = 1'b0; wr_en = 1'b0; game_clear = 1'b0;
   endtask

   initial begin
      reset = 1'b1; wr_en = 1'b0; wr_addr = 5'd0; wr_data = 32'd0;
      game_clear = 1'b0; evt_ready = 1'b0;
      mq.delete(); m_score = 32'd0; m_go = 1'b0; m_ovf = 1'b0;
      @(negedge clk);
      test_reset();
      test_up_down();
      test_win();
      test_overflow();
      test_back_to_back();
      test_ignored();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
